fetch_unit: RTL and testbench

Instruction fetch stage. It consumes the PC-steering and IF/ID stall/flush controls from the hazard controller and issues pipelined requests to instruction memory. It buffers returned instructions in a small in-order FIFO and drives the IF/ID pipeline register with instruction, PC and valid. On any redirect it discards wrong-path responses that are already in flight.

---
 rtl/fetch_unit.sv | 175 +++++++++++++++++
 tb/tb_fetch_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: steers the fetch PC, issues pipelined imem requests,
// buffers in-order responses in a small FIFO and drives the IF/ID register.
// Wrong-path responses still in flight at a redirect are counted and dropped.
module fetch_unit #(
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        new_pc_en_i,
  input  logic [1:0]  pc_sel_i,
  input  logic [31:0] jump_target_i,
  input  logic [31:0] csr_mepc_i,
  input  logic [31:0] csr_mtvec_i,
  input  logic        if_id_stall_i,
  input  logic        if_id_flush_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] if_id_instr_o,
  output logic [31:0] if_id_pc_o,
  output logic        instr_valid_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0]   CREDITS = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [31:0]      NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    PC_JUMP = 2'd0,
    PC_MEPC = 2'd1,
    PC_EXC  = 2'd2,
    PC_RSVD = 2'd3
  } pc_sel_e;

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] outst_q, outst_d;
  logic [CNT_W-1:0] discard_q, discard_d;
  logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]      fifo_instr_q [FIFO_DEPTH];
  logic [31:0]      fifo_pc_q    [FIFO_DEPTH];
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      pc_q, pc_d;
  logic             valid_q, valid_d;

  logic [31:0]  target_raw, target;
  logic [CNT_W:0] in_use;
  logic grant, drop, accept, advance, fifo_empty, pop, bypass, push;

  // Redirect target selection; the low two bits are always cleared.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    target_raw = jump_target_i;
    unique case (pc_sel_e'(pc_sel_i))
      PC_MEPC: target_raw = csr_mepc_i;
      PC_EXC:  target_raw = csr_mtvec_i;
      default: target_raw = jump_target_i;
    endcase
    target = target_raw & ~32'h3;
  end

  // Credit rule: outstanding plus buffered fetches never exceed FIFO_DEPTH,
  // so every response always has a place to land.
  assign in_use      = {1'b0, outst_q} + {1'b0, fifo_cnt_q};
  assign imem_req_o  = rstn_i && !new_pc_en_i && (in_use < CREDITS);
  assign imem_addr_o = fetch_pc_q;

  assign grant      = imem_req_o && imem_gnt_i;
  assign drop       = imem_rvalid_i && (new_pc_en_i || (discard_q != '0));
  assign accept     = imem_rvalid_i && !drop;
  assign advance    = !new_pc_en_i && !if_id_flush_i && !if_id_stall_i;
  assign fifo_empty = (fifo_cnt_q == '0);
  assign pop        = advance && !fifo_empty;
  // An empty FIFO lets an accepted response flow straight into IF/ID.
  assign bypass     = advance && fifo_empty && accept;
  assign push       = accept && !bypass;

  // Next-state for PC tracking, credit counters, FIFO pointers and IF/ID.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    outst_d    = outst_q + CNT_W'(grant) - CNT_W'(imem_rvalid_i);
    discard_d  = discard_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
    instr_d    = instr_q;
    pc_d       = pc_q;
    valid_d    = valid_q;

    if (grant)  fetch_pc_d = fetch_pc_q + 32'd4;
    if (accept) resp_pc_d  = resp_pc_q + 32'd4;
    if (imem_rvalid_i && (discard_q != '0)) discard_d = discard_q - 1'b1;
    if (pop)    rd_ptr_d = rd_ptr_q + 1'b1;
    if (push)   wr_ptr_d = wr_ptr_q + 1'b1;

    if (pop) begin
      instr_d = fifo_instr_q[rd_ptr_q];
      pc_d    = fifo_pc_q[rd_ptr_q];
      valid_d = 1'b1;
    end else if (bypass) begin
      instr_d = imem_rdata_i;
      pc_d    = resp_pc_q;
      valid_d = 1'b1;
    end else if (!if_id_stall_i || if_id_flush_i || new_pc_en_i) begin
      instr_d = NOP;
      valid_d = 1'b0;
    end

    // Redirect: restart both PCs, empty the buffer and squash what is in flight.
    if (new_pc_en_i) begin
      fetch_pc_d = target;
      resp_pc_d  = target;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fifo_cnt_d = '0;
      discard_d  = outst_q - CNT_W'(imem_rvalid_i);
    end
  end

  // Control and IF/ID state registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rstn_i) begin
      fetch_pc_q <= BOOT_ADDR;
      resp_pc_q  <= BOOT_ADDR;
      outst_q    <= '0;
      discard_q  <= '0;
      fifo_cnt_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      instr_q    <= NOP;
      pc_q       <= '0;
      valid_q    <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      fifo_cnt_q <= fifo_cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
    end
  end

  // Response buffer storage.
  // NOTE: the data array has no reset; occupancy is tracked by the reset
  // counters, so stale entries are never read.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_instr_q[wr_ptr_q] <= imem_rdata_i;
      fifo_pc_q[wr_ptr_q]    <= resp_pc_q;
    end
  end

  assign if_id_instr_o = instr_q;
  assign if_id_pc_o    = pc_q;
  assign instr_valid_o = valid_q;

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rstn_i)
    !(push && (fifo_cnt_q == FULL_CNT) && !pop));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed corner sequences, a target-mux
// vector table and a randomized phase checked against a PC-stream model.
module tb_fetch_unit;

  localparam int DEPTH = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        new_pc_en_i;
  logic [1:0]  pc_sel_i;
  logic [31:0] jump_target_i, csr_mepc_i, csr_mtvec_i;
  logic        if_id_stall_i, if_id_flush_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i, imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] if_id_instr_o, if_id_pc_o;
  logic        instr_valid_o;

  fetch_unit #(.BOOT_ADDR(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .new_pc_en_i   (new_pc_en_i),
    .pc_sel_i      (pc_sel_i),
    .jump_target_i (jump_target_i),
    .csr_mepc_i    (csr_mepc_i),
    .csr_mtvec_i   (csr_mtvec_i),
    .if_id_stall_i (if_id_stall_i),
    .if_id_flush_i (if_id_flush_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .if_id_instr_o (if_id_instr_o),
    .if_id_pc_o    (if_id_pc_o),
    .instr_valid_o (instr_valid_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] addr;
    int          ready;
  } pend_t;
  pend_t pend[$];

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] jt;
    logic [31:0] mepc;
    logic [31:0] mtvec;
    logic [31:0] exp_addr;
  } tgt_vec_t;

  int          cyc = 0;
  int          lat_mode = 0;
  int          deliveries = 0;
  logic [31:0] exp_fetch, exp_next, last_delivered;
  logic [31:0] prev_instr, prev_pc;
  logic        prev_valid;
  logic        last_req;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] target_of(input logic [1:0] sel, input logic [31:0] jt,
                                            input logic [31:0] mepc, input logic [31:0] mtvec);
    logic [31:0] t;
    case (sel)
      2'd1:    t = mepc;
      2'd2:    t = mtvec;
      default: t = jt;
    endcase
    return {t[31:2], 2'b00};
  endfunction

  // One clock cycle: drive at the falling edge, sample request before the
  // rising edge, check IF/ID just after it.
  task automatic step(input logic npc, input logic [1:0] sel, input logic [31:0] jt,
                      input logic [31:0] mepc, input logic [31:0] mtvec,
                      input logic stall, input logic flush, input logic gnt);
    logic granted;
    int   lat;
    new_pc_en_i   = npc;
    pc_sel_i      = sel;
    jump_target_i = jt;
    csr_mepc_i    = mepc;
    csr_mtvec_i   = mtvec;
    if_id_stall_i = stall;
    if_id_flush_i = flush;
    imem_gnt_i    = gnt;
    if (pend.size() > 0 && pend[0].ready <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
    end
    #1;
    last_req = imem_req_o;
    if (npc) check("req_during_redirect", {31'b0, imem_req_o}, 32'd0);
    granted = imem_req_o && gnt;
    if (granted) begin
      check("fetch_addr", imem_addr_o, exp_fetch);
      lat = (lat_mode == 0) ? 1 : (lat_mode == 1) ? 3 : int'($urandom_range(1, 3));
      pend.push_back('{addr: imem_addr_o, ready: cyc + lat});
      check("credit_cap", {31'b0, (pend.size() <= DEPTH)}, 32'd1);
    end
    if (npc) exp_fetch = target_of(sel, jt, mepc, mtvec);
    else if (granted) exp_fetch = exp_fetch + 32'd4;

    @(posedge clk_i);
    #1;
    if (npc) begin
      exp_next = target_of(sel, jt, mepc, mtvec);
      check("redirect_valid", {31'b0, instr_valid_o}, 32'd0);
      check("redirect_instr", if_id_instr_o, NOP);
    end else if (flush) begin
      check("flush_valid", {31'b0, instr_valid_o}, 32'd0);
      check("flush_instr", if_id_instr_o, NOP);
    end else if (stall) begin
      check("stall_instr", if_id_instr_o, prev_instr);
      check("stall_pc", if_id_pc_o, prev_pc);
      check("stall_valid", {31'b0, instr_valid_o}, {31'b0, prev_valid});
    end else if (instr_valid_o) begin
      check("deliver_pc", if_id_pc_o, exp_next);
      check("deliver_instr", if_id_instr_o, mem_word(exp_next));
      last_delivered = if_id_pc_o;
      exp_next = exp_next + 32'd4;
      deliveries++;
    end else begin
      check("bubble_instr", if_id_instr_o, NOP);
    end
    prev_instr = if_id_instr_o;
    prev_pc    = if_id_pc_o;
    prev_valid = instr_valid_o;
    cyc++;
    @(negedge clk_i);
  endtask

  task automatic run(input int n, input logic stall, input logic flush);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, stall, flush, 1'b1);
  endtask

  task automatic redirect(input logic [1:0] sel, input logic [31:0] jt,
                          input logic [31:0] mepc, input logic [31:0] mtvec);
    step(1'b1, sel, jt, mepc, mtvec, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    rstn_i        = 1'b0;
    new_pc_en_i   = 1'b0;
    pc_sel_i      = 2'd0;
    jump_target_i = '0;
    csr_mepc_i    = '0;
    csr_mtvec_i   = '0;
    if_id_stall_i = 1'b0;
    if_id_flush_i = 1'b0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    pend.delete();
    #1;
    check("reset_req", {31'b0, imem_req_o}, 32'd0);
    check("reset_valid", {31'b0, instr_valid_o}, 32'd0);
    check("reset_instr", if_id_instr_o, NOP);
    check("reset_pc", if_id_pc_o, 32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rstn_i     = 1'b1;
    exp_fetch  = 32'h0;
    exp_next   = 32'h0;
    prev_instr = NOP;
    prev_pc    = 32'h0;
    prev_valid = 1'b0;
  endtask

  initial begin
    tgt_vec_t vecs[6];
    int d0;
    bit found;
    vecs[0] = '{sel: 2'd0, jt: 32'h0000_0103, mepc: 32'hDEAD_0000, mtvec: 32'h0000_0001, exp_addr: 32'h0000_0100};
    vecs[1] = '{sel: 2'd2, jt: 32'h0000_0055, mepc: 32'h0000_0044, mtvec: 32'h8000_0001, exp_addr: 32'h8000_0000};
    vecs[2] = '{sel: 2'd1, jt: 32'h0000_0055, mepc: 32'h0000_0044, mtvec: 32'h8000_0001, exp_addr: 32'h0000_0044};
    vecs[3] = '{sel: 2'd3, jt: 32'h0000_0206, mepc: 32'h0000_0044, mtvec: 32'h8000_0001, exp_addr: 32'h0000_0204};
    vecs[4] = '{sel: 2'd1, jt: 32'h0000_0000, mepc: 32'h0000_0047, mtvec: 32'h0000_0000, exp_addr: 32'h0000_0044};
    vecs[5] = '{sel: 2'd2, jt: 32'h0000_0000, mepc: 32'h0000_0000, mtvec: 32'h0000_1237, exp_addr: 32'h0000_1234};

    @(negedge clk_i);
    do_reset();

    // Streaming from boot with a 1-cycle memory.
    lat_mode = 0;
    d0 = deliveries;
    run(1, 1'b0, 1'b0);
    check("first_cycle_valid", {31'b0, instr_valid_o}, 32'd0);
    run(1, 1'b0, 1'b0);
    check("first_valid", {31'b0, instr_valid_o}, 32'd1);
    check("first_pc", if_id_pc_o, 32'h0);
    run(6, 1'b0, 1'b0);
    check("stream_rate", deliveries - d0, 32'd7);

    // Four-cycle stall: credits run out, stream resumes without gaps.
    run(4, 1'b1, 1'b0);
    check("stall_req_drops", {31'b0, last_req}, 32'd0);
    run(6, 1'b0, 1'b0);

    // Stall+flush over a filled buffer; contents survive and drain in order.
    run(2, 1'b1, 1'b0);
    run(3, 1'b1, 1'b1);
    run(1, 1'b0, 1'b0);
    check("after_flush_valid", {31'b0, instr_valid_o}, 32'd1);
    run(5, 1'b0, 1'b0);

    // Two fetches in flight at 0x10/0x14 when a jump to 0x103 arrives.
    lat_mode = 1;
    redirect(2'd0, 32'h0000_0010, 32'h0, 32'h0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      run(1, 1'b0, 1'b0);
      if (pend.size() == 2 && pend[0].addr == 32'h10 && pend[1].addr == 32'h14) found = 1'b1;
    end
    check("two_outstanding", {31'b0, found}, 32'd1);
    redirect(2'd0, 32'h0000_0103, 32'h0, 32'h0);
    check("redirect_addr", imem_addr_o, 32'h0000_0100);
    d0 = deliveries;
    for (int i = 0; i < 20 && deliveries == d0; i++) run(1, 1'b0, 1'b0);
    check("redirect_delivered", {31'b0, (deliveries > d0)}, 32'd1);
    check("redirect_first_pc", last_delivered, 32'h0000_0100);

    // Target mux vector table.
    lat_mode = 0;
    foreach (vecs[i]) begin
      redirect(vecs[i].sel, vecs[i].jt, vecs[i].mepc, vecs[i].mtvec);
      check("target_addr", imem_addr_o, vecs[i].exp_addr);
      run(4, 1'b0, 1'b0);
    end

    // Redirect coinciding with a response, then fetch PC wrap-around.
    run(3, 1'b0, 1'b0);
    redirect(2'd0, 32'hFFFF_FFFC, 32'h0, 32'h0);
    check("wrap_start_addr", imem_addr_o, 32'hFFFF_FFFC);
    run(1, 1'b0, 1'b0);
    check("wrap_addr", imem_addr_o, 32'h0000_0000);
    run(4, 1'b0, 1'b0);

    // Reset in the middle of a stream.
    do_reset();
    run(5, 1'b0, 1'b0);

    // Randomized controls, grants and memory latency.
    lat_mode = 2;
    d0 = deliveries;
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 99) < 4), 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
           ($urandom_range(0, 99) < 25), ($urandom_range(0, 99) < 8), ($urandom_range(0, 99) < 75));
    end
    check("random_progress", {31'b0, ((deliveries - d0) > 100)}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
